ddr5_pwrgd_fail_detect: RTL and testbench

Per-channel DDR5 memory power-good supervisor that generates the memory fault vector consumed by the DDR5 PWRGD_FAIL LED latch. For each memory controller it qualifies PWRGD against the memory rail enable, with a power-up timeout and a glitch filter. It produces sticky fault bits, an aggregate power-good, and a fault-event pulse. It sits between the board PWRGD inputs and the fault LED latch in the power-sequencing core.

---
 rtl/ddr5_pwrgd_fail_detect.sv | 136 +++++++++++++
 tb/tb_ddr5_pwrgd_fail_detect.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr5_pwrgd_fail_detect.sv
`default_nettype none
// ============================================================================
// Module   : ddr5_pwrgd_fail_detect
// Brief    : Per-channel DDR5 PWRGD supervisor that produces sticky fault bits,
//            an aggregate power-good and a single-cycle new-fault pulse.
// Revision : 1.0 - initial release
// ============================================================================
module ddr5_pwrgd_fail_detect #(
    parameter int NUM_CH      = 4,
    parameter int TIMEOUT_CYC = 20000,
    parameter int FILTER_CYC  = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iMemPwrEn,
    input  logic [NUM_CH-1:0] iMemPwrgd,
    input  logic [NUM_CH-1:0] iChMask,
    input  logic              iClrFlt,
    output logic [NUM_CH-1:0] oCpuMemFlt,
    output logic              oMemPwrgdOk,
    output logic              oFltEvent
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int FW = $clog2(FILTER_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [FW-1:0] F_LAST = FW'(FILTER_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_PG = 2'd1,
        GOOD    = 2'd2,
        FAULT   = 2'd3
    } state_t;

    logic [NUM_CH-1:0] flt_d;
    logic [NUM_CH-1:0] good_w;
    logic [NUM_CH-1:0] flt_q;
    logic              ok_q;
    logic              ev_q;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            state_t        st_q, st_d;
            logic [TW-1:0] tcnt_q, tcnt_d;
            logic [FW-1:0] fcnt_q, fcnt_d;

            always_comb begin
                st_d   = st_q;
                tcnt_d = tcnt_q;
                fcnt_d = fcnt_q;
                if (iChMask[g]) begin
                    st_d   = IDLE;
                    tcnt_d = '0;
                    fcnt_d = '0;
                end else begin
                    case (st_q)
                        IDLE: begin
                            tcnt_d = '0;
                            fcnt_d = '0;
                            if (iMemPwrEn) st_d = WAIT_PG;
                        end
                        WAIT_PG: begin
                            // Enable drop beats PWRGD, which beats the timeout.
                            if (!iMemPwrEn) begin
                                st_d   = IDLE;
                                tcnt_d = '0;
                            end else if (iMemPwrgd[g]) begin
                                st_d   = GOOD;
                                tcnt_d = '0;
                                fcnt_d = '0;
                            end else if (tcnt_q == T_LAST) begin
                                st_d   = FAULT;
                                tcnt_d = '0;
                            end else begin
                                tcnt_d = tcnt_q + 1'b1;
                            end
                        end
                        GOOD: begin
                            if (!iMemPwrEn) begin
                                st_d   = IDLE;
                                fcnt_d = '0;
                            end else if (iMemPwrgd[g]) begin
                                fcnt_d = '0;
                            end else if (fcnt_q == F_LAST) begin
                                st_d   = FAULT;
                                fcnt_d = '0;
                            end else begin
                                fcnt_d = fcnt_q + 1'b1;
                            end
                        end
                        FAULT: begin
                            if (iClrFlt && !iMemPwrEn) st_d = IDLE;
                        end
                        default: st_d = IDLE;
                    endcase
                end
            end

            always_ff @(posedge iClk) begin
                if (iRst) begin
                    st_q   <= IDLE;
                    tcnt_q <= '0;
                    fcnt_q <= '0;
                end else begin
                    st_q   <= st_d;
                    tcnt_q <= tcnt_d;
                    fcnt_q <= fcnt_d;
                end
            end

            // A channel counts as good only if it is good now and stays good,
            // so power-good falls on the same edge a drop becomes a fault.
            assign flt_d[g]  = (st_d == FAULT);
            assign good_w[g] = iChMask[g] | ((st_q == GOOD) && (st_d == GOOD));
        end
    endgenerate

    always_ff @(posedge iClk) begin
        if (iRst) begin
            flt_q <= '0;
            ok_q  <= 1'b0;
            ev_q  <= 1'b0;
        end else begin
            flt_q <= flt_d;
            ev_q  <= |(flt_d & ~flt_q);
            ok_q  <= iMemPwrEn & (&good_w) & ~(&iChMask);
        end
    end

    assign oCpuMemFlt  = flt_q;
    assign oMemPwrgdOk = ok_q;
    assign oFltEvent   = ev_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr5_pwrgd_fail_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr5_pwrgd_fail_detect
// Brief    : Directed scenarios plus random stimulus against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr5_pwrgd_fail_detect;

    localparam int NCH = 4;
    localparam int TO  = 16;
    localparam int FI  = 3;

    logic           clk = 1'b0;
    logic           rst, en, clr;
    logic [NCH-1:0] pg, mask;
    logic [NCH-1:0] flt;
    logic           ok, ev;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ddr5_pwrgd_fail_detect #(
        .NUM_CH      (NCH),
        .TIMEOUT_CYC (TO),
        .FILTER_CYC  (FI)
    ) u_dut (
        .iClk        (clk),
        .iRst        (rst),
        .iMemPwrEn   (en),
        .iMemPwrgd   (pg),
        .iChMask     (mask),
        .iClrFlt     (clr),
        .oCpuMemFlt  (flt),
        .oMemPwrgdOk (ok),
        .oFltEvent   (ev)
    );

    // Model: phase per channel (0 off, 1 waiting, 2 good, 3 faulted),
    // number of low samples seen while waiting, current low streak while good.
    int             m_ph   [NCH];
    int             m_wait [NCH];
    int             m_low  [NCH];
    logic [NCH-1:0] m_flt;
    logic           m_ok, m_ev;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int             prev [NCH];
        logic [NCH-1:0] nf;
        logic           all_good;
        for (int c = 0; c < NCH; c++) prev[c] = m_ph[c];
        for (int c = 0; c < NCH; c++) begin
            if (rst || mask[c]) begin
                m_ph[c] = 0; m_wait[c] = 0; m_low[c] = 0;
            end else if (m_ph[c] == 0) begin
                if (en) begin m_ph[c] = 1; m_wait[c] = 0; end
            end else if (m_ph[c] == 1) begin
                if (!en) m_ph[c] = 0;
                else if (pg[c]) begin m_ph[c] = 2; m_low[c] = 0; end
                else begin
                    m_wait[c] = m_wait[c] + 1;
                    if (m_wait[c] == TO) m_ph[c] = 3;
                end
            end else if (m_ph[c] == 2) begin
                if (!en) m_ph[c] = 0;
                else if (pg[c]) m_low[c] = 0;
                else begin
                    m_low[c] = m_low[c] + 1;
                    if (m_low[c] == FI) m_ph[c] = 3;
                end
            end else begin
                if (clr && !en) m_ph[c] = 0;
            end
        end
        for (int c = 0; c < NCH; c++) nf[c] = (m_ph[c] == 3);
        all_good = 1'b1;
        for (int c = 0; c < NCH; c++)
            if (!mask[c] && !(prev[c] == 2 && m_ph[c] == 2)) all_good = 1'b0;
        m_ev  = !rst && ((nf & ~m_flt) != '0);
        m_ok  = !rst && en && all_good && (mask != '1);
        m_flt = nf;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("flt", 32'(flt), 32'(m_flt));
        chk("ok",  32'(ok),  32'(m_ok));
        chk("ev",  32'(ev),  32'(m_ev));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; pg = '0; mask = '0;
        steps(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; pg = '0; mask = '0;
        m_flt = '0; m_ok = 1'b0; m_ev = 1'b0;
        for (int c = 0; c < NCH; c++) begin m_ph[c] = 0; m_wait[c] = 0; m_low[c] = 0; end

        // Reset state
        steps(2);
        chk("rst_flt", 32'(flt), 32'h0);
        chk("rst_ok",  32'(ok),  32'h0);
        chk("rst_ev",  32'(ev),  32'h0);
        rst = 1'b0;

        // Normal power-up, PWRGD rises 5 cycles after enable
        en = 1'b1; step(); steps(4);
        pg = 4'hF; steps(3);
        chk("up_ok",  32'(ok),  32'h1);
        chk("up_flt", 32'(flt), 32'h0);

        // ch2 timeout: fault exactly 16 edges after the enable edge
        en = 1'b0; pg = '0; steps(2);
        en = 1'b1; pg = 4'b1011; step();
        steps(TO - 1);
        chk("to_early", 32'(flt), 32'h0);
        step();
        chk("to_flt", 32'(flt), 32'h4);
        chk("to_ev",  32'(ev),  32'h1);
        step();
        chk("to_ev_once", 32'(ev), 32'h0);

        // Enable low alone keeps the fault; clear with enable low removes it
        en = 1'b0; step();
        chk("to_sticky", 32'(flt), 32'h4);
        clr = 1'b1; step(); clr = 1'b0;
        chk("to_clr", 32'(flt), 32'h0);

        // PWRGD rising on the 16th cycle wins over the timeout
        en = 1'b1; step();
        steps(TO - 1);
        pg = 4'hF; step();
        chk("to_bound", 32'(flt), 32'h0);
        steps(2);

        // Glitch filter: 2 lows pass, 3 lows fault
        pg[0] = 1'b0; steps(FI - 1); pg[0] = 1'b1; step();
        chk("gl_short", 32'(flt), 32'h0);
        pg[0] = 1'b0; steps(FI);
        chk("gl_flt", 32'(flt), 32'h1);
        chk("gl_ok",  32'(ok),  32'h0);

        // Clear while enabled is ignored
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_ign", 32'(flt), 32'h1);

        // Orderly power-down: enable and all PWRGD fall together
        do_reset();
        en = 1'b1; pg = 4'hF; steps(4);
        en = 1'b0; pg = '0; steps(2);
        chk("pd_flt", 32'(flt), 32'h0);

        // Masked ch3 stuck low, then ch0/ch1 fault together
        mask = 4'b1000; en = 1'b1; pg = 4'b0111; steps(TO + 4);
        chk("msk_ok",  32'(ok),  32'h1);
        chk("msk_flt", 32'(flt), 32'h0);
        pg = 4'b0100; steps(FI);
        chk("dual_flt", 32'(flt), 32'h3);
        chk("dual_ev",  32'(ev),  32'h1);
        step();
        chk("dual_ev1", 32'(ev), 32'h0);

        // Reset in the middle of a timeout
        do_reset();
        en = 1'b1; steps(8);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rmid_all", {29'd0, flt[0] | flt[1] | flt[2] | flt[3], ok, ev}, 32'h0);
        en = 1'b0; step();

        // Random stimulus
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 7) == 0) pg[c] = ~pg[c];
            if ($urandom_range(0, 299) == 0) mask = 4'($urandom_range(0, 15));
            clr = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
